// File: rtl/closest_hit_select_pkg.sv
// Shared types and constants for the per-ray closest-hit reduction.
// Latency: n/a (types, parameters and constants only).
// Backpressure: n/a.
package closest_hit_select_pkg;

  localparam int WIDTH  = 20;   // fixed-point word, matches the box-test unit
  localparam int Q_BITS = 12;   // fractional bits, kept for consistency only
  localparam int CNT_W  = 8;    // box counter width; up to 2^CNT_W-1 boxes per ray

  localparam logic [WIDTH-1:0] MAX = 20'h7FFFF;  // "no hit" tmin sentinel

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
  } Vec3_t;

  typedef struct packed {
    Vec3_t min_pt;
    Vec3_t max_pt;
  } AABB;

  typedef struct packed {
    AABB              box;
    logic             ray_hit;
    logic [WIDTH-1:0] tmin;
    Vec3_t            normal;
  } AABB_result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_OUTPUT
  } chs_state_t;

  // Reset value of the running best and the answer for a ray that hit nothing.
  localparam AABB_result_t MISS_RESULT = '{box: '0, ray_hit: 1'b0, tmin: MAX, normal: '0};

endpackage

// File: rtl/closest_hit_select.sv
// Purpose: keeps the nearest hitting box result of one ray, then offers it downstream.
// Latency: hit_valid one cycle after the final result (or after start when box_count=0).
// Backpressure: hit_out held while hit_ready=0; upstream cannot stall, so dropped results set overflow.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   start, box_count  begin a ray expecting box_count results (accepted only when idle)
//   result_in/_valid  box-test results, one per cycle at most
//   hit_out/_valid    closest hit, valid/ready handshake with hit_ready
//   busy              not idle
//   overflow          sticky: a result arrived while not collecting
module closest_hit_select
  import closest_hit_select_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   box_count,
  input  AABB_result_t       result_in,
  input  logic               result_valid,
  output AABB_result_t       hit_out,
  output logic               hit_valid,
  input  logic               hit_ready,
  output logic               busy,
  output logic               overflow
);

  chs_state_t       state;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] received;
  logic [CNT_W-1:0] received_next;
  logic             closer;

  assign received_next = received + 1'b1;

  // Strict less-than: on equal distance the earlier result stays best.
  // A result that missed never replaces best, whatever its tmin.
  assign closer = result_in.ray_hit &&
                  ($signed(result_in.tmin) < $signed(hit_out.tmin));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      total     <= '0;
      received  <= '0;
      hit_out   <= MISS_RESULT;
      hit_valid <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            total    <= box_count;
            received <= '0;
            hit_out  <= MISS_RESULT;
            overflow <= 1'b0;
            busy     <= 1'b1;
            if (box_count == '0) begin
              state     <= ST_OUTPUT;
              hit_valid <= 1'b1;
            end else begin
              state <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (result_valid) begin
            received <= received_next;
            if (closer) begin
              hit_out <= result_in;
            end
            // The last result is folded in on the same edge that moves to OUTPUT.
            if (received_next == total) begin
              state     <= ST_OUTPUT;
              hit_valid <= 1'b1;
            end
          end
        end
        ST_OUTPUT: begin
          if (hit_ready) begin
            state     <= ST_IDLE;
            hit_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          hit_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase

      // Placed after the start-clear so a dropped result wins over the clear.
      if (result_valid && (state != ST_COLLECT)) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_closest_hit_select.sv
// Purpose: self-checking bench for closest_hit_select (ray table plus hand sequences).
// Latency: checks hit_valid one cycle after the final result.
// Backpressure: exercises hit_ready low with a dropped result during output.
module tb_closest_hit_select;
  import closest_hit_select_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] box_count;
  AABB_result_t     result_in;
  logic             result_valid;
  AABB_result_t     hit_out;
  logic             hit_valid;
  logic             hit_ready;
  logic             busy;
  logic             overflow;

  int n_cmp = 0;
  int n_bad = 0;
  AABB_result_t sb[$];

  closest_hit_select dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .box_count    (box_count),
    .result_in    (result_in),
    .result_valid (result_valid),
    .hit_out      (hit_out),
    .hit_valid    (hit_valid),
    .hit_ready    (hit_ready),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Distinct box/normal per (ray, index) so a wrong winner is visible.
  function automatic AABB_result_t mk(input int ray, input int idx, input logic hit,
                                      input logic [WIDTH-1:0] t);
    AABB_result_t r;
    r = '0;
    r.box.min_pt.x = 20'(ray * 16 + idx);
    r.box.max_pt.y = 20'(idx + 100);
    r.normal.x     = 20'(idx + 1);
    r.normal.z     = 20'(ray + 7);
    r.ray_hit      = hit;
    r.tmin         = t;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: compare on every handshake.
  always @(negedge clk) begin
    if (!reset && hit_valid && hit_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got handshake with hit_out %0h, required none", hit_out);
      end else begin
        chk("sb_hit_out", hit_out, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          n;
    logic [79:0] tm;   // tmin of result i at [i*20 +: 20]
    logic [3:0]  hit;
    int          exp;  // winning index, -1 for miss record
  } ray_t;

  ray_t rays[6];

  // Drives one ray with hit_ready high: start, n results, output cycle.
  task automatic run_ray(input int id, input ray_t r);
    AABB_result_t e;
    e = (r.exp < 0) ? MISS_RESULT : mk(id, r.exp, 1'b1, r.tm[r.exp*20 +: 20]);
    sb.push_back(e);
    start     = 1'b1;
    box_count = CNT_W'(r.n);
    tick();
    start = 1'b0;
    for (int i = 0; i < r.n; i++) begin
      result_valid = 1'b1;
      result_in    = mk(id, i, r.hit[i], r.tm[i*20 +: 20]);
      if (i == r.n - 1) chk("pre_last_hit_valid", hit_valid, 1'b0);
      tick();
    end
    result_valid = 1'b0;
    chk("lat_hit_valid", hit_valid, 1'b1);
    chk("lat_busy", busy, 1'b1);
    tick();
    chk("post_hs_busy", busy, 1'b0);
    chk("post_hs_hit_valid", hit_valid, 1'b0);
  endtask

  initial begin
    AABB_result_t e;
    rays[0] = '{n: 3, tm: {20'h0, 20'h2000, 20'h1000, 20'h3000}, hit: 4'b0111, exp: 1};
    rays[1] = '{n: 3, tm: {20'h0, MAX, 20'h10, 20'h0}, hit: 4'b0000, exp: -1};
    rays[2] = '{n: 2, tm: {20'h0, 20'h0, 20'h800, 20'h800}, hit: 4'b0011, exp: 0};
    // negative tmin is nearest; a miss with small tmin is ignored
    rays[3] = '{n: 4, tm: {20'h50, 20'hFFFFB, 20'h10, 20'h100}, hit: 4'b1101, exp: 2};
    // a hit at exactly MAX does not beat the sentinel
    rays[4] = '{n: 1, tm: {60'h0, MAX}, hit: 4'b0001, exp: -1};
    rays[5] = '{n: 0, tm: 80'h0, hit: 4'b0000, exp: -1};

    reset = 1'b1; start = 1'b0; box_count = '0; result_in = '0;
    result_valid = 1'b0; hit_ready = 1'b1;
    tick(); tick();
    chk("rst_hit_valid", hit_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_hit_out", hit_out, MISS_RESULT);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) run_ray(k, rays[k]);

    // Backpressure with a dropped result and an ignored start during output.
    hit_ready = 1'b0;
    e = mk(10, 1, 1'b1, 20'h200);
    sb.push_back(e);
    start = 1'b1; box_count = 8'd2;
    tick();
    start = 1'b0;
    result_valid = 1'b1; result_in = mk(10, 0, 1'b1, 20'h300);
    tick();
    result_in = mk(10, 1, 1'b1, 20'h200);
    tick();
    result_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin result_valid = 1'b1; result_in = mk(10, 3, 1'b1, 20'h0); end
      if (k == 2) begin start = 1'b1; box_count = 8'd0; end
      tick();
      result_valid = 1'b0; start = 1'b0;
      chk("bp_hit_valid", hit_valid, 1'b1);
      chk("bp_hit_out", hit_out, e);
      chk("bp_overflow", overflow, (k >= 1) ? 1'b1 : 1'b0);
    end
    hit_ready = 1'b1;
    tick();
    chk("bp_after_busy", busy, 1'b0);
    chk("bp_after_overflow", overflow, 1'b1);
    e = mk(11, 0, 1'b1, 20'h40);
    sb.push_back(e);
    start = 1'b1; box_count = 8'd1;
    tick();
    start = 1'b0;
    chk("start_clears_overflow", overflow, 1'b0);
    result_valid = 1'b1; result_in = e;
    tick();
    result_valid = 1'b0;
    tick();

    // Reset in the middle of a ray.
    start = 1'b1; box_count = 8'd4;
    tick();
    start = 1'b0;
    result_valid = 1'b1; result_in = mk(12, 0, 1'b1, 20'h20);
    tick();
    result_in = mk(12, 1, 1'b1, 20'h10);
    tick();
    result_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_hit_valid", hit_valid, 1'b0);
    chk("midrst_overflow", overflow, 1'b0);
    chk("midrst_hit_out", hit_out, MISS_RESULT);

    // Fresh ray; a result coinciding with start is dropped and overflow wins.
    e = mk(13, 0, 1'b1, 20'h400);
    sb.push_back(e);
    start = 1'b1; box_count = 8'd1;
    result_valid = 1'b1; result_in = mk(13, 5, 1'b1, 20'h1);
    tick();
    start = 1'b0;
    chk("start_drop_overflow", overflow, 1'b1);
    chk("start_drop_busy", busy, 1'b1);
    result_in = e;
    tick();
    result_valid = 1'b0;
    chk("fresh_hit_valid", hit_valid, 1'b1);
    tick();
    chk("fresh_busy", busy, 1'b0);
    tick();

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/closest_hit_select.md
# closest_hit_select

Per-ray reduction stage directly downstream of the AABB box-test unit. It consumes the in-order stream of `AABB_result_t` results, one per box tested against the current ray, and keeps the nearest hit. After the announced number of results has arrived, it presents a single closest-hit result to the shading/normal stage over a valid/ready handshake. Upstream has no backpressure, so this block flags any result it cannot accept.

## Interface
- `WIDTH`, 20: fixed-point word width; must match the box-test unit.
- `Q_BITS`, 12: fractional bits; carried only for package consistency, no arithmetic uses it.
- `MAX`, 20'h7FFFF: "no hit" tmin sentinel.
- `CNT_W`, 8: width of the box counter; maximum boxes per ray is 2^CNT_W−1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a new ray; accepted only in IDLE.
- `box_count`  in  CNT_W  number of results to expect for this ray; sampled with accepted `start`.
- `result_in`  in  AABB_result_t  box, ray_hit, tmin, normal from the box-test unit.
- `result_valid`  in  1  `result_in` valid this cycle (box-test unit `valid_out`).
- `hit_out`  out  AABB_result_t  closest-hit result, registered.
- `hit_valid`  out  1  `hit_out` valid; held until accepted.
- `hit_ready`  in  1  downstream accepts `hit_out` when `hit_valid && hit_ready`.
- `busy`  out  1  state ≠ IDLE.
- `overflow`  out  1  sticky: a `result_valid` was dropped.

## Operation
- FSM states:
  - IDLE → COLLECT on `start` with `box_count ≠ 0`.
  - IDLE → OUTPUT on `start` with `box_count = 0`.
  - COLLECT → OUTPUT when the accepted result is number `box_count`.
  - OUTPUT → IDLE on handshake.
- On accepted `start`:
  - Latch `box_count`.
  - Clear received counter.
  - Initialise best to ray_hit=0, tmin=MAX, box='0, normal='0.
  - Clear `overflow`.
- COLLECT, on `result_valid`:
  - Increment counter.
  - Replace best when `result_in.ray_hit && signed(result_in.tmin) < signed(best.tmin)`.
  - Strict compare: on a tie, the earliest result wins.
  - Results with ray_hit=0 never replace best, whatever their tmin.
- Compare uses signed WIDTH-bit arithmetic; no saturation needed because values are only compared.
- The final result of a ray is included in the comparison in the same cycle the transition to OUTPUT is made.
- `hit_out` = best; if no result hit, `hit_out` is the miss record (ray_hit=0, tmin=MAX).
- `start` outside IDLE is ignored, with no effect on state or outputs.
- `result_valid` in IDLE or OUTPUT is dropped and sets `overflow`. If this coincides with an accepted `start`, `overflow` still ends at 1, because set has priority over clear.

## Timing
- Reset values:
  - state=IDLE
  - `hit_valid`=0
  - `busy`=0
  - `overflow`=0
  - `hit_out`: ray_hit=0, tmin=MAX, box='0, normal='0
  - counter=0
- Reset mid-ray aborts immediately; the next cycle is IDLE with the values above.
- Latency: `hit_valid` rises the cycle after the edge that accepts the final result, or the cycle after `start` when `box_count`=0.
- `hit_out` is stable while `hit_valid`=1 and not accepted.
- Throughput: one result per cycle in COLLECT. The minimum ray period is `box_count`+2 cycles: one start cycle, N results, and a one-cycle output with `hit_ready` held high.
- `busy` deasserts the cycle after the handshake. A new `start` is accepted from that cycle on, not on the handshake cycle itself.

## Structure
- `AABB_result_t`, `Vec3_t`, and `AABB` are used from the shared types package; no new struct is needed.
- The miss-record constant (`'{box:'0, ray_hit:0, tmin:MAX, normal:'0}`) and the FSM state enum belong in the shared parameters/types package for reuse by the later scene-level reducer.
- No sub-module; the comparator is a single signed compare kept inline.

## Test plan
- start, box_count=3; results tmin {0x3000 hit, 0x1000 hit, 0x2000 hit}; `hit_ready`=1 → `hit_valid` one cycle after the 3rd result, with tmin=0x1000 and the box/normal of result 2.
- box_count=3; all ray_hit=0 with tmin {0, 0x10, MAX} → ray_hit=0, tmin=0x7FFFF.
- Ties: results tmin {0x800 hit box A, 0x800 hit box B} → box A returned.
- box_count=0 → `hit_valid` the cycle after `start`, carrying the miss record; `busy` high for exactly 1 cycle when `hit_ready`=1.
- Backpressure: `hit_ready`=0 for 5 cycles with `result_valid` pulsed once during OUTPUT → `hit_out` stable, `overflow`=1 and held through the handshake, cleared by the next `start`.
- Reset mid-ray: reset after 2 of 4 results → IDLE, all outputs at reset values. A fresh ray with box_count=1 and tmin=0x400 hit then returns tmin=0x400.
